i2c_reg_target: RTL and testbench

- I2C target (responder) modelling the register-file side of an I2C configuration write, such as the ADV7513 transfers: START, 7-bit address plus R/W, sub-address byte, then data bytes.
- Lets config-sequencer bring-up run against an on-FPGA model, and lets cores expose a register bank on the HPS/front-panel I2C bus.
- Oversamples SCL/SDA on the system clock. Stores bytes in a 256x8 register file. Reports every accepted write to the host side.

---
 rtl/i2c_reg_target_if.sv | 17 +
 rtl/i2c_reg_target.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_target_if.sv
// Host-side register-port bundle of i2c_reg_target.
//   slave  : the I2C target (drives write strobe/address/data, read data, busy)
//   master : the host logic (drives the read address, observes the rest)
//   wr_stb/wr_addr/wr_data : one-cycle report of each byte written over I2C
//   rd_addr/rd_data        : host read port, rd_data registered (1-cycle latency)
//   busy                   : a transaction addressed to this target is in progress
interface i2c_reg_target_if;
   logic       wr_stb;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;

   modport slave  (output wr_stb, wr_addr, wr_data, rd_data, busy, input  rd_addr);
   modport master (input  wr_stb, wr_addr, wr_data, rd_data, busy, output rd_addr);
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target exposing a 256x8 register file: START, 7-bit address + R/W,
// sub-address byte (loads the pointer), then data bytes written at an
// auto-incrementing pointer. SCL/SDA are oversampled on iCLK and filtered.
// Build option: define I2C_TARGET_READ_EN to support read transfers; without
// it a matching read address is NACKed and no read datapath is built.
// Ports:
//   iCLK    : system clock
//   iRST    : synchronous active-high reset
//   I2C_SCL : bus clock (never stretched)
//   I2C_SDA : open-drain data line, pulled low only while sda_oe is set
//   host    : register-port interface (slave modport)
module i2c_reg_target #(
   parameter logic [6:0]  TARGET_ADDR = 7'h39,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  I2C_SCL,
   inout  wire                   I2C_SDA,
   i2c_reg_target_if.slave       host
);

   localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK, S_SUB, S_WDATA, S_RDATA, S_RDATA_ACK, S_IGNORE
   } state_t;

   // index 0 = SCL, index 1 = SDA
   logic [1:0] sync1, sync2, filt, filt_q;
   logic [3:0] flt_cnt [2];

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic       sda_oe;
   state_t     state, ack_next;
   logic [6:0] sh;
   logic [7:0] ptr;
   logic [3:0] bit_cnt;
   logic       ack_drv;
   logic [7:0] rx_byte;
   logic       addr_hit;
   logic [7:0] regs [256];

   assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

   // Synchronise both lines, then change the filtered level only after
   // FILTER_LEN consecutive samples that disagree with it.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         sync1      <= 2'b11;
         sync2      <= 2'b11;
         filt       <= 2'b11;
         filt_q     <= 2'b11;
         flt_cnt[0] <= '0;
         flt_cnt[1] <= '0;
      end else begin
         sync1  <= {I2C_SDA, I2C_SCL};
         sync2  <= sync1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != filt[i]) begin
               if (flt_cnt[i] == CNT_MAX) begin
                  filt[i]    <= sync2[i];
                  flt_cnt[i] <= '0;
               end else begin
                  flt_cnt[i] <= flt_cnt[i] + 4'd1;
               end
            end else begin
               flt_cnt[i] <= '0;
            end
         end
      end
   end

   assign scl_rise  =  filt[0] & ~filt_q[0];
   assign scl_fall  = ~filt[0] &  filt_q[0];
   assign start_det =  filt[0] &  filt_q[0] &  filt_q[1] & ~filt[1];
   assign stop_det  =  filt[0] &  filt_q[0] & ~filt_q[1] &  filt[1];

   // Byte completed by the current rising edge; general call is never matched.
   assign rx_byte  = {sh, filt[1]};
   assign addr_hit = (rx_byte[7:1] == TARGET_ADDR) && (rx_byte[7:1] != 7'h00);

   // Register file: written one cycle after the strobe is raised, so a host
   // read of the same address in that cycle still returns the old value.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < 256; i++) regs[i] <= '0;
         host.rd_data <= '0;
      end else begin
         if (host.wr_stb) regs[host.wr_addr] <= host.wr_data;
         host.rd_data <= regs[host.rd_addr];
      end
   end

`ifdef I2C_TARGET_READ_EN
   logic [7:0] rd_byte;
   logic       mack;
   assign rd_byte = regs[ptr];
`endif

   // Protocol FSM; STOP and START override every state.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state        <= S_IDLE;
         ack_next     <= S_IDLE;
         sh           <= '0;
         ptr          <= '0;
         bit_cnt      <= '0;
         ack_drv      <= 1'b0;
         sda_oe       <= 1'b0;
         host.wr_stb  <= 1'b0;
         host.wr_addr <= '0;
         host.wr_data <= '0;
         host.busy    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
         mack         <= 1'b0;
`endif
      end else begin
         host.wr_stb <= 1'b0;
         if (stop_det) begin
            state     <= S_IDLE;
            host.busy <= 1'b0;
            sda_oe    <= 1'b0;
            ack_drv   <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            mack      <= 1'b0;
`endif
         end else if (start_det) begin
            // busy is left alone until the new address is resolved
            state   <= S_ADDR;
            bit_cnt <= '0;
            ack_drv <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            mack    <= 1'b0;
`endif
         end else begin
            case (state)
               S_ADDR: if (scl_rise) begin
                  sh      <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (addr_hit && !rx_byte[0]) begin
                        state     <= S_ACK;
                        ack_next  <= S_SUB;
                        host.busy <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                     end else if (addr_hit) begin
                        state     <= S_ACK;
                        ack_next  <= S_RDATA;
                        host.busy <= 1'b1;
`endif
                     end else begin
                        state     <= S_IGNORE;
                        host.busy <= 1'b0;
                     end
                  end
               end
               S_SUB, S_WDATA: if (scl_rise) begin
                  sh      <= rx_byte[6:0];
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     state    <= S_ACK;
                     ack_next <= S_WDATA;
                     if (state == S_SUB) begin
                        ptr <= rx_byte;
                     end else begin
                        host.wr_stb  <= 1'b1;
                        host.wr_addr <= ptr;
                        host.wr_data <= rx_byte;
                        ptr          <= ptr + 8'd1;
                     end
                  end
               end
               // First fall starts the ACK low, second fall ends it.
               S_ACK: if (scl_fall) begin
                  if (!ack_drv) begin
                     sda_oe  <= 1'b1;
                     ack_drv <= 1'b1;
                  end else begin
                     ack_drv <= 1'b0;
                     bit_cnt <= '0;
                     state   <= ack_next;
`ifdef I2C_TARGET_READ_EN
                     if (ack_next == S_RDATA) begin
                        sh     <= rd_byte[6:0];
                        sda_oe <= ~rd_byte[7];
                        ptr    <= ptr + 8'd1;
                     end else begin
                        sda_oe <= 1'b0;
                     end
`else
                     sda_oe  <= 1'b0;
`endif
                  end
               end
`ifdef I2C_TARGET_READ_EN
               S_RDATA: begin
                  if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        state  <= S_RDATA_ACK;
                     end else begin
                        sda_oe <= ~sh[6];
                        sh     <= {sh[5:0], 1'b0};
                     end
                  end
               end
               S_RDATA_ACK: begin
                  if (scl_rise) begin
                     if (filt[1]) state <= S_IGNORE;
                     else         mack  <= 1'b1;
                  end else if (scl_fall && mack) begin
                     mack    <= 1'b0;
                     bit_cnt <= '0;
                     sh      <= rd_byte[6:0];
                     sda_oe  <= ~rd_byte[7];
                     ptr     <= ptr + 8'd1;
                     state   <= S_RDATA;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master, scoreboard on the write
// report port, direct checks of ACKs, busy, read-back and SDA release.
module tb_i2c_reg_target;
   localparam int unsigned Q = 12;   // quarter bit period in system clocks

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic iCLK  = 1'b0;
   logic iRST  = 1'b1;
   logic scl   = 1'b1;
   logic m_drv = 1'b0;
   wire  sda_bus;

   int checks     = 0;
   int failures   = 0;
   int dut_drives = 0;
   wr_t exp_q [$];

   assign sda_bus = m_drv ? 1'b0 : 1'bz;
   pullup (sda_bus);

   i2c_reg_target_if hif ();

   i2c_reg_target #(.TARGET_ADDR(7'h39), .FILTER_LEN(4)) dut (
      .iCLK    (iCLK),
      .iRST    (iRST),
      .I2C_SCL (scl),
      .I2C_SDA (sda_bus),
      .host    (hif)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Write-report monitor: every strobe must match the oldest expected write.
   always @(negedge iCLK) begin
      wr_t e;
      if (hif.wr_stb === 1'b1) begin
         check("wr_stb_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_addr", hif.wr_addr, e.a);
            check("wr_data", hif.wr_data, e.d);
         end
      end
   end

   // Line held low while the master is not pulling it => target drives SDA.
   always @(negedge iCLK) if (sda_bus === 1'b0 && !m_drv) dut_drives++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      m_drv = ~b;
      wait_clk(Q);
      scl = 1'b1;
      if (glitch) begin
         wait_clk(Q / 2);
         scl = 1'b0;
         wait_clk(2);
         scl = 1'b1;
         wait_clk(2 * Q - Q / 2 - 2);
      end else begin
         wait_clk(2 * Q);
      end
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic recv_bit(output logic b);
      m_drv = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q);
      b = sda_bus;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] v);
      logic [7:0] t;
      logic       b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         t[i] = b;
      end
      send_bit(nack, 1'b0);
      v = t;
   endtask

   task automatic i2c_start();
      m_drv = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(2 * Q);
      m_drv = 1'b1;
      wait_clk(2 * Q);
      scl = 1'b0;
      wait_clk(Q);
   endtask

   task automatic i2c_stop();
      m_drv = 1'b1;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(2 * Q);
      m_drv = 1'b0;
      wait_clk(3 * Q);
   endtask

   task automatic host_read(input string name, input logic [7:0] a, input logic [7:0] exp);
      @(negedge iCLK);
      hif.rd_addr = a;
      @(negedge iCLK);
      check(name, hif.rd_data, exp);
   endtask

   // Full write transaction; every byte is expected to be ACKed.
   task automatic write_txn(input string name, input logic [7:0] bytes [$]);
      logic ack;
      i2c_start();
      foreach (bytes[i]) begin
         write_byte(bytes[i], -1, ack);
         check(name, 32'(ack), 1);
      end
      i2c_stop();
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      logic [7:0] sub;
      int         d0;

      hif.rd_addr = 8'h00;
      wait_clk(4);
      check("rst_wr_stb",  hif.wr_stb,  0);
      check("rst_wr_addr", hif.wr_addr, 0);
      check("rst_wr_data", hif.wr_data, 0);
      check("rst_rd_data", hif.rd_data, 0);
      check("rst_busy",    hif.busy,    0);
      check("rst_sda",     sda_bus,     1);
      iRST = 1'b0;
      wait_clk(20);

      // Single write
      exp_q.push_back('{a: 8'h98, d: 8'h03});
      i2c_start();
      write_byte(8'h72, -1, ack);
      check("t1_addr_ack", ack, 1);
      check("t1_busy_after_addr", hif.busy, 1);
      write_byte(8'h98, -1, ack);
      check("t1_sub_ack", ack, 1);
      write_byte(8'h03, -1, ack);
      check("t1_data_ack", ack, 1);
      i2c_stop();
      check("t1_busy_after_stop", hif.busy, 0);
      host_read("t1_rd_98", 8'h98, 8'h03);

      // Burst with pointer wrap
      exp_q.push_back('{a: 8'hFE, d: 8'hA1});
      exp_q.push_back('{a: 8'hFF, d: 8'hB2});
      exp_q.push_back('{a: 8'h00, d: 8'hC3});
      write_txn("t2_ack", '{8'h72, 8'hFE, 8'hA1, 8'hB2, 8'hC3});
      host_read("t2_rd_fe", 8'hFE, 8'hA1);
      host_read("t2_rd_ff", 8'hFF, 8'hB2);
      host_read("t2_rd_00", 8'h00, 8'hC3);

      // Wrong address
      d0 = dut_drives;
      i2c_start();
      write_byte(8'h74, -1, ack);
      check("t3_addr_nack", ack, 0);
      check("t3_busy", hif.busy, 0);
      write_byte(8'h55, -1, ack);
      check("t3_data_nack", ack, 0);
      i2c_stop();
      check("t3_sda_never_driven", 32'(dut_drives - d0), 0);

`ifdef I2C_TARGET_READ_EN
      // Read back two bytes after setting the pointer
      exp_q.push_back('{a: 8'h98, d: 8'h03});
      exp_q.push_back('{a: 8'h99, d: 8'h7A});
      write_txn("t4_wr_ack", '{8'h72, 8'h98, 8'h03, 8'h7A});
      i2c_start();
      write_byte(8'h72, -1, ack);
      check("t4_addr_w_ack", ack, 1);
      write_byte(8'h98, -1, ack);
      check("t4_sub_ack", ack, 1);
      i2c_start();
      write_byte(8'h73, -1, ack);
      check("t4_addr_r_ack", ack, 1);
      check("t4_busy", hif.busy, 1);
      read_byte(1'b0, rb);
      check("t4_rd_byte0", rb, 8'h03);
      read_byte(1'b1, rb);
      check("t4_rd_byte1", rb, 8'h7A);
      d0 = dut_drives;
      wait_clk(Q);
      check("t4_sda_released_after_nack", sda_bus, 1);
      i2c_stop();
      check("t4_no_drive_after_nack", 32'(dut_drives - d0), 0);
      check("t4_busy_after_stop", hif.busy, 0);
`else
      // Read request without read support
      d0 = dut_drives;
      i2c_start();
      write_byte(8'h73, -1, ack);
      check("t4_read_nack", ack, 0);
      check("t4_busy", hif.busy, 0);
      i2c_stop();
      check("t4_sda_never_driven", 32'(dut_drives - d0), 0);
`endif

      // SCL glitch inside the sub-address byte must not add a bit
      exp_q.push_back('{a: 8'h40, d: 8'h5A});
      i2c_start();
      write_byte(8'h72, -1, ack);
      check("t5_addr_ack", ack, 1);
      write_byte(8'h40, 5, ack);
      check("t5_sub_ack", ack, 1);
      write_byte(8'h5A, -1, ack);
      check("t5_data_ack", ack, 1);
      i2c_stop();
      host_read("t5_rd_40", 8'h40, 8'h5A);

      // Reset while the target holds an ACK low, then keep clocking a byte
      sub = 8'h10;
      i2c_start();
      write_byte(8'h72, -1, ack);
      check("t6_addr_ack", ack, 1);
      for (int i = 7; i >= 0; i--) send_bit(sub[i], 1'b0);
      m_drv = 1'b0;
      wait_clk(Q);
      scl = 1'b1;
      wait_clk(Q / 2);
      check("t6_ack_driven_pre_reset", sda_bus, 0);
      check("t6_busy_pre_reset", hif.busy, 1);
      iRST = 1'b1;
      wait_clk(1);
      check("t6_sda_released", sda_bus, 1);
      check("t6_busy_cleared", hif.busy, 0);
      wait_clk(1);
      iRST = 1'b0;
      wait_clk(Q);
      scl = 1'b0;
      wait_clk(Q);
      write_byte(8'h44, -1, ack);
      check("t6_ignored_byte_nack", ack, 0);
      i2c_stop();
      host_read("t6_regs_cleared", 8'h98, 8'h00);

      // Recovery after reset
      exp_q.push_back('{a: 8'h11, d: 8'h66});
      write_txn("t7_ack", '{8'h72, 8'h11, 8'h66});
      host_read("t7_rd_11", 8'h11, 8'h66);

      wait_clk(10);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
